// File: rtl/cfg_chain_ctrl.sv
// cfg_chain_ctrl: sequences programming of a scan-based configuration chain.
// The chain is cleared, a bitstream is shifted in one bit per accepted din
// handshake, and the configuration outputs are then released with CFGE.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | unprogrammed, waiting for start
// CLEAR  | one cycle, chain flops held in reset, bit counter cleared
// SHIFT  | accepting bitstream bits, one chain clock per accepted bit
// FLUSH  | one cycle, final chain clock pulse for the last bit
// ACTIVE | chain programmed, CFGE asserted, start reprograms
module cfg_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 16
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             din_ready,
  output logic             chain_rst,
  output logic             chain_se,
  output logic             chain_ck_en,
  output logic             chain_si,
  output logic             chain_cfge,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_FLUSH  = 3'd3,
    S_ACTIVE = 3'd4
  } state_t;

  state_t state;

  // Index of the final chain bit; accepting it ends the shift phase.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  // Handshake and activity flags decode straight from state so the bitstream
  // source sees din_ready in the same cycle the controller can take a bit.
  assign din_ready = (state == S_SHIFT);
  assign busy      = (state == S_CLEAR) || (state == S_SHIFT) || (state == S_FLUSH);

  // Sequencing FSM with all chain controls and status pulses registered.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      chain_rst   <= 1'b0;
      chain_se    <= 1'b0;
      chain_ck_en <= 1'b0;
      chain_si    <= 1'b0;
      chain_cfge  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Pulsed outputs default low; each is raised for one cycle only.
      chain_ck_en <= 1'b0;
      chain_rst   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      case (state)
        S_IDLE, S_ACTIVE: begin
          // abort is meaningless here; only start moves the FSM.
          if (start) begin
            state      <= S_CLEAR;
            chain_rst  <= 1'b1;
            chain_cfge <= 1'b0;
            chain_se   <= 1'b0;
            bit_cnt    <= '0;
          end
        end

        S_CLEAR: begin
          if (abort) begin
            state    <= S_IDLE;
            err      <= 1'b1;
            chain_se <= 1'b0;
          end else begin
            state    <= S_SHIFT;
            chain_se <= 1'b1;
          end
        end

        S_SHIFT: begin
          // abort takes priority over both start and a bit offered this cycle.
          if (abort) begin
            state    <= S_IDLE;
            err      <= 1'b1;
            chain_se <= 1'b0;
          end else if (din_valid) begin
            chain_si    <= din;
            chain_ck_en <= 1'b1;
            bit_cnt     <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_IDX) begin
              state <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          // The last chain clock pulse is already on the output this cycle.
          if (abort) begin
            state    <= S_IDLE;
            err      <= 1'b1;
            chain_se <= 1'b0;
          end else begin
            state      <= S_ACTIVE;
            chain_se   <= 1'b0;
            chain_cfge <= 1'b1;
            done       <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          chain_se   <= 1'b0;
          chain_cfge <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Directed bench for cfg_chain_ctrl with CHAIN_LEN=4. Accepted bits are
// queued as expected chain_si values and popped on each chain_ck_en pulse;
// a four-flop chain model checks the final programmed contents.
module tb_cfg_chain_ctrl;
  localparam int CHAIN_LEN = 4;
  localparam int CNT_W     = 16;

  logic             CK = 1'b0;
  logic             RSTN = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             din_ready;
  logic             chain_rst;
  logic             chain_se;
  logic             chain_ck_en;
  logic             chain_si;
  logic             chain_cfge;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic sb[$];
  logic [CHAIN_LEN-1:0] chain_m = '0;

  cfg_chain_ctrl #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .chain_rst(chain_rst), .chain_se(chain_se), .chain_ck_en(chain_ck_en),
    .chain_si(chain_si), .chain_cfge(chain_cfge), .busy(busy),
    .done(done), .err(err), .bit_cnt(bit_cnt)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the chain model from pre-edge controls, then check any
  // chain clock pulse against the scoreboard.
  task automatic tick();
    logic p_rst, p_ck, p_si, e;
    p_rst = chain_rst;
    p_ck  = chain_ck_en;
    p_si  = chain_si;
    @(posedge CK);
    if (p_rst) chain_m = '0;
    else if (p_ck) chain_m = {chain_m[CHAIN_LEN-2:0], p_si};
    #1;
    if (chain_ck_en === 1'b1) begin
      pulse_cnt++;
      chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("chain_si", {31'd0, chain_si}, {31'd0, e});
      end
    end
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    din_valid = 1'b1;
    din = b;
    while (din_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("din_ready_timeout", {31'd0, din_ready}, 32'd1);
    if (din_ready === 1'b1) begin
      chk("se_in_shift", {31'd0, chain_se}, 32'd1);
      sb.push_back(b);
      tick();
    end
  endtask

  task automatic do_pass(input logic [3:0] bits, input int gap, input logic poke_start);
    int p0;
    p0 = pulse_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_rst", {31'd0, chain_rst}, 32'd1);
    chk("clr_cfge", {31'd0, chain_cfge}, 32'd0);
    chk("clr_cnt", 32'(bit_cnt), 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd1);
    chk("clr_ready", {31'd0, din_ready}, 32'd0);
    for (int i = 3; i >= 0; i--) begin
      if (poke_start && i == 2) start = 1'b1;
      send_bit(bits[i]);
      start = 1'b0;
      if (poke_start && i == 2) begin
        chk("start_ign_rst", {31'd0, chain_rst}, 32'd0);
        chk("start_ign_cnt", 32'(bit_cnt), 32'd2);
      end
      if (i == 2 && gap > 0) begin
        din_valid = 1'b0;
        repeat (gap) begin
          tick();
          chk("gap_ck_en", {31'd0, chain_ck_en}, 32'd0);
          chk("gap_cnt", 32'(bit_cnt), 32'd2);
        end
      end
    end
    din_valid = 1'b0;
    chk("flush_ready", {31'd0, din_ready}, 32'd0);
    chk("flush_ck_en", {31'd0, chain_ck_en}, 32'd1);
    chk("flush_se", {31'd0, chain_se}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd1);
    chk("flush_cfge", {31'd0, chain_cfge}, 32'd0);
    tick();
    chk("act_done", {31'd0, done}, 32'd1);
    chk("act_cfge", {31'd0, chain_cfge}, 32'd1);
    chk("act_cnt", 32'(bit_cnt), 32'd4);
    chk("act_se", {31'd0, chain_se}, 32'd0);
    chk("act_ck_en", {31'd0, chain_ck_en}, 32'd0);
    chk("act_busy", {31'd0, busy}, 32'd0);
    chk("chain_data", {28'd0, chain_m}, {28'd0, bits});
    chk("pulse_count", 32'(pulse_cnt - p0), 32'd4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("cfge_hold", {31'd0, chain_cfge}, 32'd1);
  endtask

  task automatic abort_pass(input logic with_start);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    din = 1'b1;
    din_valid = 1'b1;
    abort = 1'b1;
    start = with_start;
    tick();
    abort = 1'b0;
    start = 1'b0;
    din_valid = 1'b0;
    chk("abt_err", {31'd0, err}, 32'd1);
    chk("abt_busy", {31'd0, busy}, 32'd0);
    chk("abt_ready", {31'd0, din_ready}, 32'd0);
    chk("abt_ck_en", {31'd0, chain_ck_en}, 32'd0);
    chk("abt_cfge", {31'd0, chain_cfge}, 32'd0);
    chk("abt_cnt", 32'(bit_cnt), 32'd2);
    chk("abt_rst", {31'd0, chain_rst}, 32'd0);
    tick();
    chk("abt_err_end", {31'd0, err}, 32'd0);
    repeat (3) begin
      tick();
      chk("abt_no_done", {31'd0, done}, 32'd0);
      chk("abt_idle", {31'd0, busy}, 32'd0);
    end
    chk("abt_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {20'd0, bit_cnt[7:0], chain_rst, chain_se, chain_ck_en, chain_si}, 32'd0);
    chk(tag, {27'd0, chain_cfge, done, err, busy, din_ready}, 32'd0);
  endtask

  initial begin
    #12;
    chk_all_zero("reset_outputs");
    @(posedge CK);
    #1;
    RSTN = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_wait_start", {31'd0, busy}, 32'd0);
      chk("idle_rst", {31'd0, chain_rst}, 32'd0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_err", {31'd0, err}, 32'd0);
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);

    do_pass(4'b1011, 0, 1'b0);
    do_pass(4'b0110, 0, 1'b0);
    do_pass(4'b1011, 3, 1'b0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("act_abort_err", {31'd0, err}, 32'd0);
    chk("act_abort_cfge", {31'd0, chain_cfge}, 32'd1);

    abort_pass(1'b0);
    do_pass(4'b1001, 0, 1'b1);
    abort_pass(1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    RSTN = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sb.delete();
    tick();
    tick();
    chk_all_zero("held_reset");
    RSTN = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_no_done", {31'd0, done}, 32'd0);
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
    end
    do_pass(4'b1101, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cfg_chain_ctrl.md
CFG_CHAIN_CTRL -- requirements
Module: cfg_chain_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 32, meaning: number of configuration flops in the controlled scan chain (legal values are 2 or more).
REQ-002 Parameter CNT_W, default 16, meaning: bit-counter width (must satisfy 2^CNT_W > CHAIN_LEN).
REQ-003 Port CK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request to (re)program the chain; sampled per cycle.
REQ-006 Port abort  input  1  cancel programming in progress.
REQ-007 Port din_valid  input  1  bitstream bit available.
REQ-008 Port din  input  1  bitstream bit; the first bit accepted ends up in the last flop of the chain.
REQ-009 Port din_ready  output  1  controller accepts din this cycle.
REQ-010 Port chain_rst  output  1  active-high asynchronous reset to chain flops (RST).
REQ-011 Port chain_se  output  1  scan enable to chain flops (SE).
REQ-012 Port chain_ck_en  output  1  chain clock enable; the chain shifts on a CK edge only when this is 1.
REQ-013 Port chain_si  output  1  scan input to the first chain flop (SI).
REQ-014 Port chain_cfge  output  1  configure enable to chain flops (CFGE); releases CFGQ/CFGQN.
REQ-015 Port busy  output  1  high in CLEAR, SHIFT and FLUSH.
REQ-016 Port done  output  1  one-cycle pulse when programming completes.
REQ-017 Port err  output  1  one-cycle pulse when programming is aborted.
REQ-018 Port bit_cnt  output  CNT_W  number of bits accepted in the current pass.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, SHIFT, FLUSH and ACTIVE.
REQ-020 IDLE or ACTIVE with start=1 SHALL go to CLEAR on the next edge.
REQ-021 CLEAR SHALL last exactly one cycle, with chain_rst=1, chain_cfge=0 and bit_cnt cleared to 0, then go to SHIFT.
REQ-022 In SHIFT, din_ready SHALL be 1, chain_se SHALL be 1, and a bit is accepted when din_valid and din_ready are both 1.
REQ-023 On each accepted bit, chain_si SHALL be registered with din and chain_ck_en SHALL pulse for exactly the following cycle; bit_cnt SHALL increment by 1.
REQ-024 With din_valid=0, no bit is accepted, chain_ck_en SHALL be 0, and state and bit_cnt SHALL hold.
REQ-025 Acceptance with bit_cnt==CHAIN_LEN-1 SHALL go to FLUSH, and din_ready SHALL drop on the next edge.
REQ-026 FLUSH SHALL last one cycle, during which the final chain_ck_en pulse occurs and chain_se stays 1; it then goes to ACTIVE.
REQ-027 Entering ACTIVE, done SHALL pulse one cycle and chain_cfge SHALL become 1 and stay 1 while in ACTIVE.
REQ-028 In ACTIVE, chain_se=0 and chain_ck_en=0; bit_cnt SHALL hold CHAIN_LEN.
REQ-029 start in CLEAR, SHIFT or FLUSH SHALL be ignored.
REQ-030 abort=1 in CLEAR, SHIFT or FLUSH SHALL go to IDLE, pulse err, force chain_ck_en=0 and keep chain_cfge=0; any bit offered in that same cycle is not accepted.
REQ-031 abort has no effect in IDLE or ACTIVE.
REQ-032 start and abort both 1 in SHIFT: abort SHALL win.
REQ-033 din_ready SHALL never be 1 outside SHIFT; chain_ck_en SHALL pulse exactly CHAIN_LEN times per completed pass.
REQ-034 All outputs except din_ready and busy SHALL be registered; din_ready and busy SHALL be decoded from state only.

Reset
REQ-035 RSTN=0 SHALL immediately force state IDLE, bit_cnt=0, chain_rst=0, chain_se=0, chain_ck_en=0, chain_si=0, chain_cfge=0, done=0 and err=0, regardless of CK.
REQ-036 Reset asserted mid-SHIFT or in ACTIVE SHALL drop chain_cfge asynchronously; no done pulse SHALL follow.
REQ-037 After RSTN deasserts, the first state change SHALL require start.

Verification (CHAIN_LEN=4)
REQ-038 Scenario, normal pass: start pulse, din_valid held 1 with bits 1,0,1,1 -> CLEAR 1 cycle with chain_rst=1; 4 chain_ck_en pulses carrying SI 1,0,1,1; FLUSH; done pulse; chain_cfge=1; bit_cnt=4.
REQ-039 Scenario, stalled bitstream: bits 1,0,1,1 offered with din_valid low for 3 cycles between the 2nd and 3rd bits -> no chain_ck_en during the gap; bit_cnt holds 2; final result identical to the normal pass.
REQ-040 Scenario, abort: abort after 2 accepted bits -> err pulse; state IDLE; chain_cfge=0; no done pulse.
REQ-041 Scenario, reprogramming: start while ACTIVE -> chain_cfge falls in CLEAR, chain_rst pulses, the new 4-bit pass completes, chain_cfge returns to 1.
REQ-042 Scenario, async reset: RSTN low mid-SHIFT between edges -> all outputs 0 immediately; a start after release reruns the full pass.
REQ-043 Scenario, ignored and simultaneous controls: start during SHIFT is ignored; start and abort together in SHIFT -> IDLE with an err pulse.
